canvas_write_scheduler: RTL and testbench
=========================================

# canvas_write_scheduler

Single-write-port scheduler for the drawing-canvas layers. It merges freehand-tool pixel writes with a hardware clear engine. The clear engine sweeps every pixel of one layer, or of all layers, writing the empty colour. The block sits between the freehand tool / layer selector and the canvas write ports, and issues at most one registered pixel write per clock.

## Interface
- WIDTH, 640, canvas width in pixels
- HEIGHT, 480, canvas height in pixels
- LAYERS, 4, number of canvas layers (power of two, ≥2)
- COLOR_W, 4, pixel colour width
- CLEAR_COLOR, 0, colour written by the clear engine (the empty/transparent colour)
- clk  in  1  system clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- tool_valid  in  1  tool write request
- tool_ready  out  1  tool write can be accepted this cycle
- tool_layer  in  $clog2(LAYERS)  target layer of tool write
- tool_x  in  $clog2(WIDTH)  tool pixel x
- tool_y  in  $clog2(HEIGHT)  tool pixel y
- tool_color  in  COLOR_W  tool pixel colour
- clear_req  in  1  start clear (sampled only in IDLE)
- clear_all  in  1  sampled with clear_req: 1 = clear every layer, 0 = clear clear_layer only
- clear_layer  in  $clog2(LAYERS)  layer to clear when clear_all=0
- clear_busy  out  1  sweep in progress
- clear_done  out  1  one-cycle pulse after the final clear write
- wr_en  out  1  write strobe to the canvas selected by wr_layer
- wr_layer  out  $clog2(LAYERS)  target layer
- wr_x  out  $clog2(WIDTH)  write x
- wr_y  out  $clog2(HEIGHT)  write y
- wr_color  out  COLOR_W  write colour

## Operation
- States: IDLE, SWEEP, DONE.
- IDLE:
  - clear_req=1 → SWEEP.
  - Load sweep pointer sx=0, sy=0.
  - Load sl = (clear_all ? 0 : clear_layer); latch the all-flag.
- SWEEP:
  - Pointer advances only on cycles where the clear engine wins the port.
  - sx increments and wraps to 0 at WIDTH-1, then sy increments.
  - At (WIDTH-1, HEIGHT-1): if all-flag and sl≠LAYERS-1, then sl++ and sx=sy=0. Otherwise → DONE.
- DONE: lasts one cycle, then → IDLE.
- Arbitration each cycle, tool first:
  - tool_ready = ~(state==SWEEP && tool_layer==sl).
  - Tool write accepted when tool_valid && tool_ready.
  - If a tool write is accepted, the clear engine stalls that cycle.
  - Otherwise, in SWEEP, the clear engine writes (sl, sx, sy, CLEAR_COLOR).
- Tool writes to a layer not currently being swept are never blocked.
- Tool writes to the layer being swept are back-pressured until the sweep moves to another layer or ends.
- In IDLE and DONE, tool_ready=1.
- clear_req is ignored outside IDLE; a held clear_req restarts the sweep only after returning to IDLE.
- Widths: pointer compares use full-width constants WIDTH-1 and HEIGHT-1. No pointer ever exceeds WIDTH-1 or HEIGHT-1, so non-power-of-two sizes are legal.

## Timing
- Reset (async assert): IDLE; wr_en=0; wr_layer=wr_x=wr_y=wr_color=0; clear_busy=0; clear_done=0; pointers 0.
- Reset mid-sweep abandons the sweep with no clear_done. After release: IDLE, tool_ready=1.
- wr_* outputs are registered: the winning write is presented one cycle after the edge where it is granted. wr_en is otherwise 0 and the other wr_* fields hold their last values.
- clear_busy and clear_done are registered:
  - clear_busy is 1 exactly while state==SWEEP.
  - clear_done is 1 exactly while state==DONE.
- Uncontended single-layer clear, with clear_req sampled at edge 0:
  - clear_busy=1 after edge 0.
  - Clear writes visible after edges 1…WIDTH·HEIGHT.
  - After edge WIDTH·HEIGHT: clear_busy=0, clear_done=1 for one cycle.
- Each accepted tool write during SWEEP delays completion by exactly one cycle.
- clear_all takes LAYERS·WIDTH·HEIGHT clear-write cycles, with no gap between layers.
- tool_ready is combinational from tool_layer and state (and sl). tool_valid must not depend on tool_ready.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2, LAYERS=4, CLEAR_COLOR=0.
- **Reset:** drive reset_n=0 mid-sweep → all outputs 0 immediately. After release, tool write (L1,(3,1),c=5) → wr_en pulse with L1,3,1,5 one cycle later; clear_done never asserts.
- **Single-layer clear:** clear_req, clear_layer=2, clear_all=0 at edge 0 → 8 writes to L2 in order (0,0),(1,0)…(3,1), colour 0, after edges 1–8; clear_done=1 only after edge 8; clear_busy=0 thereafter.
- **Contention:** clear L2 while tool_valid on L1 for 3 consecutive cycles → 3 tool writes appear interleaved; clear still produces all 8 pixels with none skipped or duplicated; clear_done after edge 11.
- **Back-pressure:** during a clear of L2, tool_valid on L2 → tool_ready=0, no tool write issued. After clear_done, tool_ready=1 and the write proceeds.
- **Clear all:** clear_req with clear_all=1 → 32 contiguous writes covering L0..L3, 8 per layer; clear_done once after edge 32.
- **Ignored request:** clear_req re-asserted during SWEEP → no restart, identical write sequence; clear_req held through DONE → a new sweep starts on the first IDLE sample.

Source files
------------

// File: rtl/canvas_write_scheduler.sv
// canvas_write_scheduler
// ----------------------
// Shares the single canvas write port between freehand-tool pixel writes and
// a clear engine. The clear engine walks x, then y, then layer, writing
// CLEAR_COLOR to every pixel of one layer or of all layers. The tool always
// wins arbitration. Tool writes aimed at the layer currently being swept are
// back-pressured until the sweep leaves that layer.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   tool_valid/ready    tool write handshake (see below)
//   tool_layer/x/y/color  tool write payload
//   clear_req           start a sweep (sampled only in IDLE)
//   clear_all           with clear_req: 1 = all layers, 0 = clear_layer only
//   clear_layer         layer to clear when clear_all = 0
//   clear_busy          registered, 1 while sweeping
//   clear_done          registered, one-cycle pulse after the final clear write
//   wr_en/layer/x/y/color  registered canvas write port
//   dbg_state           current FSM state (IDLE=0, SWEEP=1, DONE=2)
//
// Handshake: a tool write transfers on a rising edge where tool_valid and
// tool_ready are both 1. tool_ready is combinational from state, the swept
// layer and tool_layer. The producer must not make tool_valid depend on
// tool_ready. It may keep tool_valid asserted with stable payload until the
// transfer happens.

module canvas_write_scheduler #(
  parameter int                 WIDTH       = 640,
  parameter int                 HEIGHT      = 480,
  parameter int                 LAYERS      = 4,
  parameter int                 COLOR_W     = 4,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        tool_valid,
  output logic                        tool_ready,
  input  logic [$clog2(LAYERS)-1:0]   tool_layer,
  input  logic [$clog2(WIDTH)-1:0]    tool_x,
  input  logic [$clog2(HEIGHT)-1:0]   tool_y,
  input  logic [COLOR_W-1:0]          tool_color,
  input  logic                        clear_req,
  input  logic                        clear_all,
  input  logic [$clog2(LAYERS)-1:0]   clear_layer,
  output logic                        clear_busy,
  output logic                        clear_done,
  output logic                        wr_en,
  output logic [$clog2(LAYERS)-1:0]   wr_layer,
  output logic [$clog2(WIDTH)-1:0]    wr_x,
  output logic [$clog2(HEIGHT)-1:0]   wr_y,
  output logic [COLOR_W-1:0]          wr_color,
  output logic [1:0]                  dbg_state
);

  localparam int LW = $clog2(LAYERS);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LAYERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Sweep pointer and latched all-layers flag
  logic [XW-1:0] r_sx;
  logic [YW-1:0] r_sy;
  logic [LW-1:0] r_sl;
  logic          r_all;

  // Registered outputs
  logic          r_wr_en;
  logic [LW-1:0] r_wr_layer;
  logic [XW-1:0] r_wr_x;
  logic [YW-1:0] r_wr_y;
  logic [COLOR_W-1:0] r_wr_color;
  logic          r_busy;
  logic          r_done;

  // Next values for the registered outputs
  logic          w_wr_en_next;
  logic [LW-1:0] w_wr_layer_next;
  logic [XW-1:0] w_wr_x_next;
  logic [YW-1:0] w_wr_y_next;
  logic [COLOR_W-1:0] w_wr_color_next;
  logic          w_busy_next;
  logic          w_done_next;

  logic w_tool_ready;
  logic w_tool_accept;
  logic w_clear_win;
  logic w_x_last;
  logic w_y_last;
  logic w_layer_last;
  logic w_sweep_last;

  // Only the layer under the sweep is blocked; every other layer passes.
  assign w_tool_ready  = !((r_state == ST_SWEEP) && (tool_layer == r_sl));
  assign w_tool_accept = tool_valid && w_tool_ready;
  // The clear engine only gets the port when the tool is not using it.
  assign w_clear_win   = (r_state == ST_SWEEP) && !w_tool_accept;

  assign w_x_last     = (r_sx == X_LAST);
  assign w_y_last     = (r_sy == Y_LAST);
  // A single-layer sweep ends on its own layer; an all-layer sweep on the top one.
  assign w_layer_last = !r_all || (r_sl == L_LAST);
  assign w_sweep_last = w_x_last && w_y_last && w_layer_last;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (clear_req) w_state_next = ST_SWEEP;
      ST_SWEEP: if (w_clear_win && w_sweep_last) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output logic (values registered below)
  // ---------------------------------------------------------------------
  always_comb begin
    w_wr_en_next    = 1'b0;
    w_wr_layer_next = r_wr_layer;
    w_wr_x_next     = r_wr_x;
    w_wr_y_next     = r_wr_y;
    w_wr_color_next = r_wr_color;
    if (w_tool_accept) begin
      w_wr_en_next    = 1'b1;
      w_wr_layer_next = tool_layer;
      w_wr_x_next     = tool_x;
      w_wr_y_next     = tool_y;
      w_wr_color_next = tool_color;
    end else if (w_clear_win) begin
      w_wr_en_next    = 1'b1;
      w_wr_layer_next = r_sl;
      w_wr_x_next     = r_sx;
      w_wr_y_next     = r_sy;
      w_wr_color_next = CLEAR_COLOR;
    end
    // Status flags follow the state that is entered on this edge, so the
    // registered copies track the state register exactly.
    w_busy_next = (w_state_next == ST_SWEEP);
    w_done_next = (w_state_next == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en    <= 1'b0;
      r_wr_layer <= '0;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_wr_color <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr_en    <= w_wr_en_next;
      r_wr_layer <= w_wr_layer_next;
      r_wr_x     <= w_wr_x_next;
      r_wr_y     <= w_wr_y_next;
      r_wr_color <= w_wr_color_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  // ---------------------------------------------------------------------
  // Sweep pointer: loaded on a request in IDLE, advanced only on cycles
  // where the clear engine actually writes.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sx  <= '0;
      r_sy  <= '0;
      r_sl  <= '0;
      r_all <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (clear_req) begin
        r_sx  <= '0;
        r_sy  <= '0;
        r_sl  <= clear_all ? '0 : clear_layer;
        r_all <= clear_all;
      end
    end else if (w_clear_win) begin
      if (!w_x_last) begin
        r_sx <= r_sx + XW'(1);
      end else begin
        r_sx <= '0;
        if (!w_y_last) begin
          r_sy <= r_sy + YW'(1);
        end else begin
          r_sy <= '0;
          if (!w_layer_last) r_sl <= r_sl + LW'(1);
        end
      end
    end
  end

  assign tool_ready = w_tool_ready;
  assign clear_busy = r_busy;
  assign clear_done = r_done;
  assign wr_en      = r_wr_en;
  assign wr_layer   = r_wr_layer;
  assign wr_x       = r_wr_x;
  assign wr_y       = r_wr_y;
  assign wr_color   = r_wr_color;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_canvas_write_scheduler.sv
// Testbench for canvas_write_scheduler (WIDTH=4, HEIGHT=2, LAYERS=4).
// The reference model keeps the outstanding clear pixels in a queue, in
// layer/y/x order. On each cycle an accepted tool write goes out first.
// Otherwise the head pixel of the queue is written.
module tb_canvas_write_scheduler;

  localparam int WIDTH   = 4;
  localparam int HEIGHT  = 2;
  localparam int LAYERS  = 4;
  localparam int COLOR_W = 4;
  localparam int LW = $clog2(LAYERS);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [COLOR_W-1:0] CLR = '0;

  typedef struct packed {
    logic [LW-1:0] l;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pix_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic               tool_valid = 1'b0;
  logic               tool_ready;
  logic [LW-1:0]      tool_layer = '0;
  logic [XW-1:0]      tool_x = '0;
  logic [YW-1:0]      tool_y = '0;
  logic [COLOR_W-1:0] tool_color = '0;
  logic               clear_req = 1'b0;
  logic               clear_all = 1'b0;
  logic [LW-1:0]      clear_layer = '0;
  logic               clear_busy;
  logic               clear_done;
  logic               wr_en;
  logic [LW-1:0]      wr_layer;
  logic [XW-1:0]      wr_x;
  logic [YW-1:0]      wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic [1:0]         dbg_state;

  canvas_write_scheduler #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LAYERS(LAYERS),
    .COLOR_W(COLOR_W), .CLEAR_COLOR(CLR)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .tool_valid(tool_valid), .tool_ready(tool_ready),
    .tool_layer(tool_layer), .tool_x(tool_x), .tool_y(tool_y),
    .tool_color(tool_color),
    .clear_req(clear_req), .clear_all(clear_all), .clear_layer(clear_layer),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .wr_en(wr_en), .wr_layer(wr_layer), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;
  pix_t m_q[$];                  // pending clear pixels
  logic m_done_state = 1'b0;     // model is in the one-cycle done phase
  logic [LW-1:0]      m_wl = '0;
  logic [XW-1:0]      m_wx = '0;
  logic [YW-1:0]      m_wy = '0;
  logic [COLOR_W-1:0] m_wc = '0;
  logic               m_wen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_sweep(input logic all, input logic [LW-1:0] lay);
    for (int l = 0; l < LAYERS; l++)
      if (all || (l == int'(lay)))
        for (int y = 0; y < HEIGHT; y++)
          for (int x = 0; x < WIDTH; x++)
            m_q.push_back('{l: LW'(l), x: XW'(x), y: YW'(y)});
  endtask

  // One clock cycle: check tool_ready, advance the model, check outputs.
  task automatic tick();
    logic exp_ready, was_idle, was_sweep;
    pix_t p;
    #1;
    was_sweep = (m_q.size() > 0);
    was_idle  = !was_sweep && !m_done_state;
    exp_ready = !(was_sweep && (tool_layer == m_q[0].l));
    check("tool_ready", 32'(tool_ready), 32'(exp_ready));
    m_wen = 1'b0;
    if (tool_valid && exp_ready) begin
      m_wen = 1'b1; m_wl = tool_layer; m_wx = tool_x; m_wy = tool_y; m_wc = tool_color;
    end else if (was_sweep) begin
      p = m_q.pop_front();
      m_wen = 1'b1; m_wl = p.l; m_wx = p.x; m_wy = p.y; m_wc = CLR;
    end
    m_done_state = was_sweep && (m_q.size() == 0);
    if (was_idle && clear_req) start_sweep(clear_all, clear_layer);
    @(posedge clk);
    #1;
    check("wr_en",      32'(wr_en),      32'(m_wen));
    check("wr_layer",   32'(wr_layer),   32'(m_wl));
    check("wr_x",       32'(wr_x),       32'(m_wx));
    check("wr_y",       32'(wr_y),       32'(m_wy));
    check("wr_color",   32'(wr_color),   32'(m_wc));
    check("clear_busy", 32'(clear_busy), 32'(m_q.size() > 0));
    check("clear_done", 32'(clear_done), 32'(m_done_state));
  endtask

  task automatic check_reset_outputs();
    check("rst_wr_en",    32'(wr_en),      32'd0);
    check("rst_wr_layer", 32'(wr_layer),   32'd0);
    check("rst_wr_x",     32'(wr_x),       32'd0);
    check("rst_wr_y",     32'(wr_y),       32'd0);
    check("rst_wr_color", 32'(wr_color),   32'd0);
    check("rst_busy",     32'(clear_busy), 32'd0);
    check("rst_done",     32'(clear_done), 32'd0);
    check("rst_ready",    32'(tool_ready), 32'd1);
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    reset_n = 1'b0; tool_valid = 1'b0; clear_req = 1'b0;
    #1;
    check_reset_outputs();
    m_q.delete();
    m_done_state = 1'b0;
    m_wen = 1'b0; m_wl = '0; m_wx = '0; m_wy = '0; m_wc = '0;
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  // Run cycles until clear_done is seen; return how many edges it took.
  task automatic run_to_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((clear_done !== 1'b1) && (n < 200));
  endtask

  task automatic set_tool(input logic v, input int l, input int x, input int y, input int c);
    tool_valid = v; tool_layer = LW'(l); tool_x = XW'(x); tool_y = YW'(y);
    tool_color = COLOR_W'(c);
  endtask

  task automatic request(input logic all, input int lay);
    clear_req = 1'b1; clear_all = all; clear_layer = LW'(lay);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-sweep, then a tool write on L1 after release
    request(1'b0, 2); tick(); clear_req = 1'b0;
    tick(); tick(); tick();
    do_reset();
    set_tool(1'b1, 1, 3, 1, 5); tick();
    set_tool(1'b0, 0, 0, 0, 0); tick(); tick();

    // Uncontended single-layer clear of L2
    request(1'b0, 2); tick(); clear_req = 1'b0;
    run_to_done(n);
    check("single_len", 32'(n), 32'd8);
    tick(); tick();

    // Contention: tool on L1 for three cycles during a clear of L2
    request(1'b0, 2); tick(); clear_req = 1'b0;
    set_tool(1'b1, 1, 0, 1, 7); tick();
    set_tool(1'b1, 1, 1, 1, 8); tick();
    set_tool(1'b1, 1, 2, 0, 9); tick();
    set_tool(1'b0, 0, 0, 0, 0);
    run_to_done(n);
    check("contend_len", 32'(n + 3), 32'd11);
    tick();

    // Back-pressure: tool held on L2 during a clear of L2
    request(1'b0, 2); tick(); clear_req = 1'b0;
    set_tool(1'b1, 2, 3, 0, 12);
    run_to_done(n);
    check("bp_len", 32'(n), 32'd8);
    tick();                       // DONE: tool write proceeds
    set_tool(1'b0, 0, 0, 0, 0); tick();

    // Clear all layers
    request(1'b1, 3); tick(); clear_req = 1'b0;
    run_to_done(n);
    check("all_len", 32'(n), 32'd32);
    tick();

    // clear_req held throughout: no restart mid-sweep, restart after DONE
    request(1'b0, 1); tick();
    run_to_done(n);
    check("held_len", 32'(n), 32'd8);
    tick();                       // DONE, request ignored
    tick();                       // IDLE sample starts a new sweep
    check("restart_busy", 32'(clear_busy), 32'd1);
    clear_req = 1'b0;
    run_to_done(n);
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      tool_valid  = ($urandom_range(0, 1) == 1);
      tool_layer  = LW'($urandom_range(0, LAYERS - 1));
      tool_x      = XW'($urandom_range(0, WIDTH - 1));
      tool_y      = YW'($urandom_range(0, HEIGHT - 1));
      tool_color  = COLOR_W'($urandom);
      clear_req   = ($urandom_range(0, 9) == 0);
      clear_all   = ($urandom_range(0, 3) == 0);
      clear_layer = LW'($urandom_range(0, LAYERS - 1));
      if (i == 200) do_reset();
      else tick();
    end
    set_tool(1'b0, 0, 0, 0, 0);
    clear_req = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
